// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin stream arbiter.
//   arb_state_e : arbiter FSM state encoding
//   MaxReq      : largest supported requester count
//   ptr_next()  : priority pointer increment modulo the requester count
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int MaxReq = 16;

    // Any pointer at or beyond the last index folds back to 0, so a
    // non-power-of-two requester count can never leave an out-of-range index.
    function automatic int ptr_next(input int ptr, input int num_req);
        if (ptr >= num_req - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/dff.sv
// Single-bit register with load enable and synchronous reset.
//   clk_i : clock
//   rst_i : synchronous active-high reset, loads ResetVal
//   en_i  : load enable
//   d_i   : next value
//   q_o   : registered value
module dff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= ResetVal;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the request vector is rotated so that
// index ptr_i sits at bit 0, the lowest set bit is isolated, and the result
// is rotated back to requester positions.
//   req_i    : request vector
//   ptr_i    : highest-priority index
//   winner_o : one-hot winner (zero when nothing requests)
//   found_o  : at least one request present
module rr_priority_pick #(
    parameter int NumReq = 4,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] winner_o,
    output logic              found_o
);

    logic [NumReq-1:0] rotated;
    logic [NumReq-1:0] rot_onehot;

    // Doubling the vector turns the rotate into a plain shift.
    assign rotated    = NumReq'({req_i, req_i} >> ptr_i);
    assign rot_onehot = rotated & (~rotated + NumReq'(1));
    assign winner_o   = NumReq'(({rot_onehot, rot_onehot} << ptr_i) >> NumReq);
    assign found_o    = |req_i;

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter sharing one valid/ready byte stream between
// NumReq sources. A winner keeps the output until it transfers a beat with
// last set; the next search then starts at the following requester.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   req_valid_i  : per-requester beat valid
//   req_data_i   : per-requester data, requester k at [k*Width +: Width]
//   req_last_i   : per-requester end-of-packet
//   req_ready_o  : per-requester ready (only the granted one follows ready_i)
//   valid_o      : downstream valid
//   data_o       : downstream data (zero while idle)
//   last_o       : downstream end-of-packet
//   ready_i      : downstream ready
//   grant_o      : one-hot current grant, zero while idle
//   busy_o       : a packet is locked
//
// state      | meaning
// -----------+---------------------------------------------------------
// ARB_IDLE   | no grant; pick the next requester starting at ptr_r
// ARB_LOCKED | grant_r owns the stream until its last beat transfers
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int Width  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*Width-1:0] req_data_i,
    input  logic [NumReq-1:0]       req_last_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    valid_o,
    output logic [Width-1:0]        data_o,
    output logic                    last_o,
    input  logic                    ready_i,
    output logic [NumReq-1:0]       grant_o,
    output logic                    busy_o
);

    localparam int PtrW = $clog2(NumReq);

    if (NumReq < 2 || NumReq > MaxReq) begin : g_bad_num_req
        $error("rr_stream_arbiter: NumReq must be between 2 and MaxReq");
    end

    logic              state_q;
    arb_state_e        state_r;
    arb_state_e        state_d;
    logic [NumReq-1:0] grant_r;
    logic [NumReq-1:0] grant_d;
    logic [PtrW-1:0]   ptr_r;
    logic [PtrW-1:0]   ptr_d;
    logic              arb_en;
    logic              ptr_en;

    logic [NumReq-1:0] pick_winner;
    logic              pick_found;
    logic [PtrW-1:0]   g_idx;
    logic [Width-1:0]  data_mux;
    logic              xfer_last;

    assign state_r = arb_state_e'(state_q);

    rr_priority_pick #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_pick (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_r),
        .winner_o (pick_winner),
        .found_o  (pick_found)
    );

    // grant_r is zero outside LOCKED, so the mux yields all-zero outputs
    // while idle without needing the state term.
    always_comb begin
        data_mux = '0;
        g_idx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (grant_r[k]) begin
                data_mux = data_mux | req_data_i[k*Width +: Width];
                g_idx    = g_idx | PtrW'(k);
            end
        end
    end

    assign valid_o     = |(req_valid_i & grant_r);
    assign last_o      = |(req_last_i & grant_r);
    assign data_o      = data_mux;
    assign req_ready_o = grant_r & {NumReq{ready_i}};
    assign grant_o     = grant_r;
    assign busy_o      = (state_r == ARB_LOCKED);
    assign xfer_last   = valid_o & ready_i & last_o;

    always_comb begin
        state_d = state_r;
        grant_d = grant_r;
        ptr_d   = ptr_r;
        arb_en  = 1'b0;
        ptr_en  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_winner;
                    arb_en  = 1'b1;
                end
            end
            ARB_LOCKED: begin
                if (xfer_last) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = PtrW'(ptr_next(int'(g_idx), NumReq));
                    arb_en  = 1'b1;
                    ptr_en  = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                arb_en  = 1'b1;
            end
        endcase
    end

    dff #(.ResetVal(1'b0)) u_state_dff (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (arb_en),
        .d_i   (state_d),
        .q_o   (state_q)
    );

    for (genvar k = 0; k < NumReq; k++) begin : g_grant
        dff #(.ResetVal(1'b0)) u_grant_dff (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (arb_en),
            .d_i   (grant_d[k]),
            .q_o   (grant_r[k])
        );
    end

    for (genvar b = 0; b < PtrW; b++) begin : g_ptr
        dff #(.ResetVal(1'b0)) u_ptr_dff (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (ptr_en),
            .d_i   (ptr_d[b]),
            .q_o   (ptr_r[b])
        );
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready byte stream between NumReq upstream packet sources, e.g. several vision pipeline stages sharing the single UART/SPI output path.
- Grants whole packets: once a requester wins, the grant is locked until that requester transfers a beat with last asserted. There is no preemption.
- Sits between the processing stages and the output serializer.

Parameters:
- NumReq, 4, number of requesters; legal values are 2 to 16.
- Width, 8, data width of each stream beat.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NumReq  per-requester beat valid
- req_data_i  in  NumReq*Width  per-requester data; requester k occupies bits [k*Width +: Width]
- req_last_i  in  NumReq  per-requester end-of-packet flag, qualified by valid
- req_ready_o  out  NumReq  per-requester ready
- valid_o  out  1  downstream beat valid
- data_o  out  Width  downstream data
- last_o  out  1  downstream end-of-packet flag
- ready_i  in  1  downstream ready
- grant_o  out  NumReq  one-hot current grant; all zeros when idle
- busy_o  out  1  high while in LOCKED

Behaviour:
- State machine with two states, IDLE and LOCKED. Registered state: state_r, grant_r (one-hot), ptr_r (clog2(NumReq) bits, the highest-priority index).
- Reset values: state IDLE, grant_r 0, ptr_r 0. As a result, grant_o=0, busy_o=0, valid_o=0, req_ready_o=0 and last_o=0 throughout reset and in the first cycle after it. data_o=0 while idle.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit scanning ptr_r, ptr_r+1, ..., wrapping modulo NumReq.
  - Register the winner as one-hot grant_r and move to LOCKED.
  - Otherwise stay in IDLE.
  - No beat is transferred while in IDLE: all req_ready_o=0 and valid_o=0.
- LOCKED with grant index g:
  - valid_o=req_valid_i[g], data_o=req_data_i[g], last_o=req_last_i[g]. This output path is purely combinational through the mux, with no added latency.
  - req_ready_o[g]=ready_i; all other req_ready_o bits are 0.
  - A transfer occurs when valid_o and ready_i are both high.
  - On a transfer with last_o=1: return to IDLE, clear grant_r, set ptr_r=(g+1) mod NumReq.
  - If req_valid_i[g] drops mid-packet, the grant is held. Other requesters wait indefinitely.
- Latency:
  - The first beat can be presented the cycle after the request is first seen in IDLE (1 cycle of arbitration).
  - There is exactly one idle bubble cycle between consecutive packets, including back-to-back packets from the same requester.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NumReq-1,0.
- Wrap-around: ptr_r at NumReq-1 advances to 0. For non-power-of-two NumReq, the increment saturates back to 0; it must never hold an out-of-range index.
- Simultaneous events:
  - A requester raising valid in the same cycle that the last beat of another packet transfers is evaluated in the following IDLE cycle.
  - A single-beat packet (last on the first beat) locks for one transfer cycle only.
- Reset mid-packet: the next cycle is IDLE with all outputs at their reset values. The partially sent packet is abandoned; upstream recovery is the sources' responsibility.
- Invariants:
  - grant_o is always one-hot or zero.
  - busy_o equals (state_r==LOCKED).
  - Data never passes from a non-granted requester.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCKED);
  - the MaxReq=16 constant;
  - a function for the modulo-NumReq pointer increment.
- Sub-module rr_priority_pick: a combinational rotate / priority-encode / unrotate. Inputs are a request vector and ptr; outputs are a one-hot winner and a found flag. It is parameterized by NumReq.
- State, grant and pointer registers are built from single-bit dff instances with en_i, ResetVal 0, sharing clk_i/rst_i.

Test Plan:
- After reset, all requesters valid with 2-beat packets and ready_i=1 → grant order 0,1,2,3,0. Each packet shows 1 arbitration cycle, 2 transfer cycles, then 1 bubble.
- Only requester 2 valid, sending 3 packets of 1 beat each (data 0xA1, 0xA2, 0xA3) → data_o shows A1, A2, A3 on alternate cycles, with grant_o=0b0100 during each transfer.
- Requester 1 locked; drop req_valid_i[1] for 3 cycles mid-packet while requester 0 is valid → grant_o stays 0b0010, req_ready_o[0]=0, valid_o=0, no data leaks.
- ready_i held low 5 cycles during requester 3's packet → data_o is stable, req_ready_o[3]=0, no transfer. On release the beat transfers once, and ptr wraps to 0 after last.
- Assert rst_i for 1 cycle mid-packet (requester 1, beat 2 of 4) → the following cycle has grant_o=0, busy_o=0, valid_o=0. The next arbitration starts from ptr 0.
- NumReq=3 build, all valid → grants rotate 0,1,2,0,1 and the pointer never reaches 3.
